// File: rtl/ci_arb_pkg.sv
// Shared types and constants for the CI CAM access-port arbiter.
// Address layout on the CAM port: [16]=REG#, [15]=io/mem, [14:0]=offset.
package ci_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StDone,
      StLocked
   } arb_state_e;

   localparam int unsigned CAM_ADDR_W     = 18;
   localparam int unsigned CAM_DATA_W     = 8;
   localparam logic [7:0]  ABORT_READDATA = 8'hFF;
   localparam int unsigned REG_BIT        = 16;
   localparam int unsigned IO_BIT         = 15;

endpackage

// File: rtl/ci_rr_pick.sv
// Round-robin priority pick: one-hot of the first active request at or after ptr.
module ci_rr_pick #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  pick,
   output logic             valid
);

   // Walk offsets from farthest to nearest so the nearest active request wins.
   always_comb begin
      pick = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(k + int'(ptr)) % NREQ]) begin
            pick = '0;
            pick[(k + int'(ptr)) % NREQ] = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/ci_cam_arbiter.sv
// Shares the CI bridge CAM port between NREQ requesters: round-robin grant per access,
// optional lock for multi-access sequences, and a per-access watchdog for a stuck WAIT#.
module ci_cam_arbiter
   import ci_arb_pkg::*;
#(
   parameter int unsigned NREQ            = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 12000000,
   parameter int unsigned TMO_W           = 24,
   parameter int unsigned LOCK_MAX_CYCLES = 60000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_read,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ-1:0]            req_lock,
   input  logic [CAM_ADDR_W*NREQ-1:0] req_address,
   input  logic [CAM_DATA_W*NREQ-1:0] req_writedata,
   output logic [NREQ-1:0]            req_waitreq,
   output logic [CAM_DATA_W-1:0]      req_readdata,
   output logic [NREQ-1:0]            req_timeout,
   output logic [NREQ-1:0]            grant,
   output logic                       cam_read,
   output logic                       cam_write,
   output logic [CAM_ADDR_W-1:0]      cam_address,
   output logic [CAM_DATA_W-1:0]      cam_writedata,
   input  logic                       cam_waitreq,
   input  logic [CAM_DATA_W-1:0]      cam_readdata
);

   localparam int unsigned       IDX_W     = $clog2(NREQ);
   localparam int unsigned       LOCK_W    = $clog2(LOCK_MAX_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX_CYCLES - 1);

   arb_state_e            state;
   logic [IDX_W-1:0]      gidx, ptr, pick_idx, sel_idx, next_ptr;
   logic [NREQ-1:0]       strobe, pick;
   logic                  pick_valid, is_read, discard, lost;
   logic [TMO_W-1:0]      wdog;
   logic [LOCK_W-1:0]     lock_cnt;
   logic [CAM_ADDR_W-1:0] sel_addr;
   logic [CAM_DATA_W-1:0] sel_wdata;

   assign strobe = req_read | req_write;

   ci_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (IDX_W)
   ) u_pick (
      .req   (strobe),
      .ptr   (ptr),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

   // While locked only the owner can start an access, so it is the mux source.
   assign sel_idx   = (state == StLocked) ? gidx : pick_idx;
   assign sel_addr  = req_address[sel_idx*CAM_ADDR_W +: CAM_ADDR_W];
   assign sel_wdata = req_writedata[sel_idx*CAM_DATA_W +: CAM_DATA_W];
   assign next_ptr  = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
   // Owner abandoned its strobe: finish on the bridge but suppress its result pulse.
   assign lost      = discard || !strobe[gidx];

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= StIdle;
         grant         <= '0;
         gidx          <= '0;
         ptr           <= '0;
         is_read       <= 1'b0;
         discard       <= 1'b0;
         wdog          <= '0;
         lock_cnt      <= '0;
         cam_read      <= 1'b0;
         cam_write     <= 1'b0;
         cam_address   <= '0;
         cam_writedata <= '0;
         req_waitreq   <= '1;
         req_readdata  <= '0;
         req_timeout   <= '0;
      end else begin
         req_waitreq <= '1;
         req_timeout <= '0;
         unique case (state)
            StIdle: begin
               if (pick_valid) begin
                  grant         <= pick;
                  gidx          <= pick_idx;
                  is_read       <= req_read[sel_idx];
                  cam_address   <= sel_addr;
                  cam_writedata <= sel_wdata;
                  discard       <= 1'b0;
                  state         <= StIssue;
               end
            end
            StIssue: begin
               cam_read  <= is_read;
               cam_write <= !is_read;
               wdog      <= '0;
               discard   <= lost;
               state     <= StWait;
            end
            StWait: begin
               discard <= lost;
               if (!cam_waitreq || wdog == TMO_LAST) begin
                  cam_read  <= 1'b0;
                  cam_write <= 1'b0;
                  if (!lost) begin
                     req_waitreq[gidx] <= 1'b0;
                     req_timeout[gidx] <= cam_waitreq;
                  end
                  if (cam_waitreq) req_readdata <= ABORT_READDATA;
                  else if (is_read) req_readdata <= cam_readdata;
                  state <= StDone;
               end else begin
                  wdog <= wdog + TMO_W'(1);
               end
            end
            StDone: begin
               if (req_lock[gidx]) begin
                  lock_cnt <= '0;
                  state    <= StLocked;
               end else begin
                  grant <= '0;
                  ptr   <= next_ptr;
                  state <= StIdle;
               end
            end
            StLocked: begin
               if (strobe[gidx]) begin
                  is_read       <= req_read[sel_idx];
                  cam_address   <= sel_addr;
                  cam_writedata <= sel_wdata;
                  discard       <= 1'b0;
                  state         <= StIssue;
               end else if (!req_lock[gidx] || lock_cnt == LOCK_LAST) begin
                  grant <= '0;
                  ptr   <= next_ptr;
                  state <= StIdle;
               end else begin
                  lock_cnt <= lock_cnt + LOCK_W'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ci_cam_arbiter.sv
// Directed bench for ci_cam_arbiter with a scripted CAM bridge and completion/bus scoreboards.
module tb_ci_cam_arbiter;
   import ci_arb_pkg::*;

   localparam int unsigned NREQ = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_read, req_write, req_lock, req_waitreq, req_timeout, grant;
   logic [35:0] req_address;
   logic [15:0] req_writedata;
   logic [7:0]  req_readdata, cam_writedata, cam_readdata;
   logic        cam_read, cam_write, cam_waitreq;
   logic [17:0] cam_address;

   always #5 clk = ~clk;

   ci_cam_arbiter #(
      .NREQ            (NREQ),
      .TIMEOUT_CYCLES  (100),
      .TMO_W           (24),
      .LOCK_MAX_CYCLES (50)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_read      (req_read),
      .req_write     (req_write),
      .req_lock      (req_lock),
      .req_address   (req_address),
      .req_writedata (req_writedata),
      .req_waitreq   (req_waitreq),
      .req_readdata  (req_readdata),
      .req_timeout   (req_timeout),
      .grant         (grant),
      .cam_read      (cam_read),
      .cam_write     (cam_write),
      .cam_address   (cam_address),
      .cam_writedata (cam_writedata),
      .cam_waitreq   (cam_waitreq),
      .cam_readdata  (cam_readdata)
   );

   // Bridge: holds WAIT# for bridge_wait cycles of each strobe, then completes.
   int         bridge_wait;
   logic [7:0] bridge_rdata;
   int         bcnt;
   always @(posedge clk) begin
      if (reset || !(cam_read || cam_write)) bcnt <= 0;
      else bcnt <= bcnt + 1;
   end
   assign cam_waitreq  = (cam_read || cam_write) ? (bcnt < bridge_wait) : 1'b1;
   assign cam_readdata = bridge_rdata;

   typedef struct { int id; bit rd; logic [7:0] rdata; bit tmo; } comp_t;
   typedef struct { logic [17:0] addr; logic [7:0] wdata; bit wr; } bus_t;
   comp_t comp_q[$];
   bus_t  bus_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   localparam logic [17:0] A_IO  = 18'd1 << IO_BIT;
   localparam logic [17:0] A_REG = 18'd1 << REG_BIT;
   logic [17:0] lock_addr [4];
   logic [7:0]  lock_data [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int id, input bit rd, input logic [17:0] addr,
                        input logic [7:0] wd);
      req_read[id]              = rd;
      req_write[id]             = !rd;
      req_address[id*18 +: 18]  = addr;
      req_writedata[id*8 +: 8]  = wd;
   endtask

   task automatic expect_acc(input int id, input bit rd, input logic [17:0] addr,
                             input logic [7:0] wd, input logic [7:0] rdata);
      comp_q.push_back('{id, rd, rdata, 1'b0});
      bus_q.push_back('{addr, wd, !rd});
   endtask

   task automatic wait_done(input int id);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_waitreq[id] !== 1'b0 && n < 300);
      check($sformatf("done_req%0d", id), req_waitreq[id], 0);
      @(posedge clk);
      #1;
      req_read[id]  = 1'b0;
      req_write[id] = 1'b0;
   endtask

   // Bridge-side scoreboard: every completed CAM access must match the expected order.
   always @(negedge clk) begin
      bus_t b;
      if (!reset && (cam_read || cam_write) && !cam_waitreq) begin
         check("bus_expected", bus_q.size() != 0, 1);
         if (bus_q.size() != 0) begin
            b = bus_q.pop_front();
            check("bus_addr", cam_address, b.addr);
            check("bus_dir", cam_write, b.wr);
            check("bus_rd_excl", cam_read, !b.wr);
            if (b.wr) check("bus_wdata", cam_writedata, b.wdata);
         end
      end
   end

   // Requester-side scoreboard: completion owner, timeout flag and read data.
   always @(negedge clk) begin
      comp_t c;
      for (int i = 0; i < NREQ; i++) begin
         if (!reset && req_waitreq[i] === 1'b0) begin
            check("comp_expected", comp_q.size() != 0, 1);
            if (comp_q.size() != 0) begin
               c = comp_q.pop_front();
               check("comp_id", i, c.id);
               check("comp_timeout", req_timeout[i], c.tmo);
               if (c.rd) check("comp_rdata", req_readdata, c.rdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int hi;
      lock_addr = '{A_IO | 18'h1, A_IO | 18'h3, A_IO | 18'h2, A_IO | 18'h0};
      lock_data = '{8'h81, 8'h00, 8'h04, 8'hAA};
      reset = 1'b1;
      req_read = '0; req_write = '0; req_lock = '0;
      req_address = '0; req_writedata = '0;
      bridge_wait = 0; bridge_rdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_cam_read", cam_read, 0);
      check("rst_cam_write", cam_write, 0);
      check("rst_cam_address", cam_address, 0);
      check("rst_cam_writedata", cam_writedata, 0);
      check("rst_req_waitreq", req_waitreq, 2'b11);
      check("rst_req_readdata", req_readdata, 0);
      check("rst_req_timeout", req_timeout, 0);
      check("rst_grant", grant, 0);

      // Single read: strobe in cycle 2, WAIT# low in cycle 5, DONE in cycle 6.
      bridge_wait = 3; bridge_rdata = 8'h40;
      expect_acc(0, 1, A_IO | 18'h1, 8'h00, 8'h40);
      @(posedge clk); #1 drive(0, 1, A_IO | 18'h1, 8'h00);
      n = 0; hi = 0;
      do begin
         @(negedge clk);
         n++;
         if (cam_read) hi++;
      end while (req_waitreq[0] !== 1'b0 && n < 50);
      check("rd_latency", n, 7);
      check("rd_strobe_cycles", hi, 4);
      check("rd_grant_in_done", grant, 2'b01);
      @(posedge clk); #1 req_read[0] = 1'b0;
      @(negedge clk);
      check("rd_waitreq_one_cycle", req_waitreq, 2'b11);
      check("rd_grant_free", grant, 0);

      // req1 alone moves the pointer back to 0.
      bridge_wait = 1;
      expect_acc(1, 0, A_REG | 18'h4, 8'h11, 8'h00);
      drive(1, 0, A_REG | 18'h4, 8'h11);
      wait_done(1);

      // Simultaneous writes: req0 first; req0 re-requesting then yields to req1.
      bridge_wait = 2;
      expect_acc(0, 0, A_IO | 18'h10, 8'h21, 8'h00);
      expect_acc(1, 0, A_IO | 18'h11, 8'h22, 8'h00);
      expect_acc(0, 0, A_IO | 18'h12, 8'h23, 8'h00);
      @(posedge clk); #1;
      drive(0, 0, A_IO | 18'h10, 8'h21);
      drive(1, 0, A_IO | 18'h11, 8'h22);
      wait_done(0);
      drive(0, 0, A_IO | 18'h12, 8'h23);
      wait_done(1);
      wait_done(0);

      // Locked four-write sequence on req1 with req0 stalled behind it.
      bridge_wait = 2; bridge_rdata = 8'h3C; req_lock[1] = 1'b1;
      for (int k = 0; k < 4; k++) expect_acc(1, 0, lock_addr[k], lock_data[k], 8'h00);
      expect_acc(0, 1, A_REG | 18'h20, 8'h00, 8'h3C);
      @(posedge clk); #1 drive(1, 0, lock_addr[0], lock_data[0]);
      @(posedge clk); #1 drive(0, 1, A_REG | 18'h20, 8'h00);
      for (int k = 0; k < 4; k++) begin
         wait_done(1);
         if (k == 3) begin
            req_lock[1] = 1'b0;
         end else begin
            @(negedge clk);
            check("lock_grant_held", grant, 2'b10);
            check("lock_req0_stalled", req_waitreq[0], 1);
            @(posedge clk); #1 drive(1, 0, lock_addr[k+1], lock_data[k+1]);
         end
      end
      wait_done(0);

      // Watchdog: 100 WAIT cycles of stuck WAIT#, then abort with 8'hFF.
      bridge_wait = 1000000;
      comp_q.push_back('{0, 1'b1, ABORT_READDATA, 1'b1});
      @(posedge clk); #1 drive(0, 1, A_IO | 18'h30, 8'h00);
      n = 0; hi = 0;
      do begin
         @(negedge clk);
         n++;
         if (cam_read) hi++;
      end while (req_waitreq[0] !== 1'b0 && n < 300);
      check("tmo_strobe_cycles", hi, 100);
      check("tmo_latency", n, 103);
      @(posedge clk); #1 req_read[0] = 1'b0;
      @(negedge clk);
      check("tmo_bus_free", grant, 0);
      check("tmo_pulse_one_cycle", req_timeout, 0);

      // Reset during WAIT abandons the access; the next one runs normally.
      @(posedge clk); #1 drive(0, 1, A_REG | 18'h2, 8'h00);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rstw_in_wait", cam_read, 1);
      @(posedge clk); #1;
      reset = 1'b1; req_read = '0; req_write = '0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rstw_cam_read", cam_read, 0);
      check("rstw_grant", grant, 0);
      check("rstw_waitreq", req_waitreq, 2'b11);
      bridge_wait = 0; bridge_rdata = 8'h5A;
      expect_acc(0, 1, A_REG | 18'h2, 8'h00, 8'h5A);
      drive(0, 1, A_REG | 18'h2, 8'h00);
      wait_done(0);

      // Idle lock: 50 LOCKED cycles, one IDLE cycle, req0 granted in the next.
      bridge_wait = 1; bridge_rdata = 8'h77; req_lock[1] = 1'b1;
      expect_acc(1, 0, A_IO | 18'h1, 8'h81, 8'h00);
      expect_acc(0, 1, A_IO | 18'h40, 8'h00, 8'h77);
      drive(1, 0, A_IO | 18'h1, 8'h81);
      wait_done(1);
      drive(0, 1, A_IO | 18'h40, 8'h00);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 25) check("flock_grant_held", grant, 2'b10);
      end while (grant !== 2'b01 && n < 200);
      check("flock_release_cycles", n, 52);
      wait_done(0);
      req_lock[1] = 1'b0;

      repeat (5) @(negedge clk);
      check("comp_q_drained", comp_q.size(), 0);
      check("bus_q_drained", bus_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ci_cam_arbiter.md
Name: ci_cam_arbiter

Overview:
Shares the single CAM access port of the CI bridge between NREQ requesters, e.g. the USB CI_RW command engine and a background CAM status/IREQ poller.
- Round-robin grant per transaction.
- Optional lock, so a requester can run an uninterrupted multi-access sequence (HC set / size / data / HC clear).
- Per-transaction watchdog, so a hung CAM (WAIT# stuck) cannot stall the bus.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT_CYCLES, 12000000, cycles a single access may stay in wait before abort (200 ms at 60 MHz)
TMO_W, 24, watchdog counter width; must hold TIMEOUT_CYCLES
LOCK_MAX_CYCLES, 60000000, maximum idle lock hold before forced release (1 s)

Ports:
clk  in  1  system clock (60 MHz)
reset  in  1  synchronous, active-high
req_read  in  NREQ  per-requester read strobe, held until its req_waitreq is low
req_write  in  NREQ  per-requester write strobe, held until its req_waitreq is low
req_lock  in  NREQ  keep grant after current access completes
req_address  in  18*NREQ  packed; [16]=REG#, [15]=io/mem, [14:0]=offset
req_writedata  in  8*NREQ  packed write data
req_waitreq  out  NREQ  high = stall; low for exactly 1 cycle = access complete
req_readdata  out  8  shared read data, valid in the completion cycle
req_timeout  out  NREQ  1-cycle pulse coincident with an aborted completion
grant  out  NREQ  one-hot current owner, 0 when bus is free
cam_read  out  1  to bridge
cam_write  out  1  to bridge
cam_address  out  18  to bridge
cam_writedata  out  8  to bridge
cam_waitreq  in  1  bridge stall
cam_readdata  in  8  bridge read data

Behaviour:
- Reset values: cam_read=0, cam_write=0, cam_address=0, cam_writedata=0, req_waitreq=all 1, req_readdata=0, req_timeout=0, grant=0. Round-robin pointer = 0. Lock cleared. State = IDLE.
- States: IDLE, ISSUE, WAIT, DONE, LOCKED.
- IDLE: if any (req_read|req_write), ci_rr_pick selects the first active requester at or after the pointer. Register grant, address and writedata. Go to ISSUE.
- ISSUE (1 cycle): drive cam_read or cam_write with the registered address/data. Clear the watchdog. Go to WAIT.
- Read+write both high on one requester: read wins, write ignored.
- WAIT: strobe stays asserted. When cam_waitreq is sampled low:
  - drop the strobe next cycle;
  - latch cam_readdata into req_readdata (reads only; unchanged on writes);
  - drive req_waitreq[g]=0 for one cycle (DONE).
- Watchdog: if cam_waitreq is still high after TIMEOUT_CYCLES in WAIT:
  - drop the strobe;
  - req_readdata=8'hFF;
  - pulse req_timeout[g] with req_waitreq[g]=0.
- Latency: request seen in cycle 0; strobe at the bridge in cycle 2; completion 1 cycle after cam_waitreq low; minimum 4 cycles per access.
- DONE → LOCKED if req_lock[g]=1. Otherwise → IDLE, with pointer = g+1 mod NREQ.
- LOCKED: only requester g is serviced (→ ISSUE on its strobe); all other requests stay stalled.
  - req_lock[g] low while g has no strobe → IDLE, pointer advanced.
  - LOCK_MAX_CYCLES with no strobe from g → forced release.
- Non-granted requesters always see req_waitreq=1. grant stays valid from ISSUE through DONE and in LOCKED.
- Requester dropping its strobe mid-access is a protocol violation. The arbiter completes the access anyway and discards the result pulse.
- Reset mid-access: strobes low on the next edge, grant and lock cleared. Any bridge access in flight is abandoned; the bridge has its own reset.
- Simultaneous new request and completion: the new request is arbitrated in the following IDLE cycle. No back-to-back grant within DONE.

Decomposition:
- Package ci_arb_pkg:
  - state enum (IDLE..LOCKED);
  - CAM_ADDR_W=18, CAM_DATA_W=8;
  - ABORT_READDATA=8'hFF;
  - address-field bit positions REG_BIT=16, IO_BIT=15.
- Sub-module ci_rr_pick: combinational rotate/priority encoder. Inputs: request vector, pointer. Outputs: one-hot pick, valid.

Test Plan:
- Single read, req0 (addr 18'h08001), bridge waitreq low after 3 cycles, readdata 8'h40 → cam_read high 4 cycles; req_waitreq[0] low 1 cycle; req_readdata=8'h40; grant back to 0.
- req0 and req1 write simultaneously, pointer=0 → req0 serviced first, then req1; the next simultaneous pair starts with req1.
- req1 asserts req_lock across 4 writes (8'h81 to 18'h08001, size hi/lo, data), req0 requesting throughout → req0 stalled until req1 drops lock; req0 then granted in the next IDLE.
- cam_waitreq held high, TIMEOUT_CYCLES=100 in bench → abort at cycle 100 of WAIT; req_timeout[0] pulse; req_readdata=8'hFF; bus free after.
- reset asserted during WAIT → cam_read=0 and grant=0 next cycle; a subsequent request is serviced normally.
- Lock held with no strobe, LOCK_MAX_CYCLES=50 in bench → forced release after 50 cycles; a pending req0 is granted.
